// File: rtl/dmac_fifo_pkg.sv
// rtl/dmac_fifo_pkg.sv - shared state encodings and default widths for the FIFO slice
package dmac_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WRITE    = 3'd1,
      ST_READ     = 3'd2,
      ST_WR_ERROR = 3'd3,
      ST_RD_ERROR = 3'd4,
      ST_WR_RD    = 3'd5
   } state_t;

endpackage

// File: rtl/dmac_fifo_param_if.sv
// rtl/dmac_fifo_param_if.sv - request/data/status bundle between a FIFO user and dmac_fifo_param
interface dmac_fifo_param_if
   import dmac_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  wr_ack;
   logic                  wr_err;
   logic                  rd_ack;
   logic                  rd_err;
   logic [ADDR_WIDTH:0]   data_count;
   state_t                state;

   modport master (
      output wr_en, din, rd_en,
      input  dout, full, empty, almost_full, almost_empty,
      input  wr_ack, wr_err, rd_ack, rd_err, data_count, state
   );

   modport slave (
      input  wr_en, din, rd_en,
      output dout, full, empty, almost_full, almost_empty,
      output wr_ack, wr_err, rd_ack, rd_err, data_count, state
   );

endinterface

// File: rtl/dmac_fifo_next_calc.sv
// rtl/dmac_fifo_next_calc.sv - combinational accept/next-pointer/next-count/next-state logic
module dmac_fifo_next_calc
   import dmac_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] head,
   input  logic [ADDR_WIDTH-1:0] tail,
   input  logic [ADDR_WIDTH:0]   count,
   input  logic                  full,
   input  logic                  empty,
   output logic                  we,
   output logic                  re,
   output logic [ADDR_WIDTH-1:0] next_head,
   output logic [ADDR_WIDTH-1:0] next_tail,
   output logic [ADDR_WIDTH:0]   next_count,
   output state_t                next_state
);

   always_comb begin
      we         = 1'b0;
      re         = 1'b0;
      next_state = ST_IDLE;
      unique case ({wr_en, rd_en})
         2'b10: begin
            we         = !full;
            next_state = full ? ST_WR_ERROR : ST_WRITE;
         end
         2'b01: begin
            re         = !empty;
            next_state = empty ? ST_RD_ERROR : ST_READ;
         end
         2'b11: begin
            // A full FIFO still takes both: the read frees the slot the write fills.
            we         = 1'b1;
            re         = !empty;
            next_state = empty ? ST_WRITE : ST_WR_RD;
         end
         default: ;
      endcase
   end

   always_comb begin
      next_head  = re ? head + ADDR_WIDTH'(1) : head;
      next_tail  = we ? tail + ADDR_WIDTH'(1) : tail;
      next_count = count;
      if (we && !re) next_count = count + (ADDR_WIDTH+1)'(1);
      if (re && !we) next_count = count - (ADDR_WIDTH+1)'(1);
   end

endmodule

// File: rtl/dmac_fifo_param.sv
// rtl/dmac_fifo_param.sv - parameterised synchronous FIFO: registers, storage array and flag decode
module dmac_fifo_param
   import dmac_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   dmac_fifo_param_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] head, tail, next_head, next_tail;
   logic [ADDR_WIDTH:0]   count, next_count;
   logic [DATA_WIDTH-1:0] dout_q;
   state_t                state_q, next_state;
   logic                  wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
   logic                  we, re, full, empty;

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   dmac_fifo_next_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_next (
      .wr_en      (bus.wr_en),
      .rd_en      (bus.rd_en),
      .head       (head),
      .tail       (tail),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .we         (we),
      .re         (re),
      .next_head  (next_head),
      .next_tail  (next_tail),
      .next_count (next_count),
      .next_state (next_state)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         dout_q   <= '0;
         state_q  <= ST_IDLE;
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
         rd_ack_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         head     <= next_head;
         tail     <= next_tail;
         count    <= next_count;
         state_q  <= next_state;
         wr_ack_q <= we;
         wr_err_q <= bus.wr_en && !we;
         rd_ack_q <= re;
         rd_err_q <= bus.rd_en && !re;
         if (re) dout_q <= mem[head];
      end
   end

   // Storage is not reset; the reset_n term only blocks a write racing a reset edge.
   always_ff @(posedge clk) begin
      if (we && reset_n) mem[tail] <= bus.din;
   end

   assign bus.dout         = dout_q;
   assign bus.state        = state_q;
   assign bus.data_count   = count;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count >= AF_C);
   assign bus.almost_empty = (count <= AE_C);
   assign bus.wr_ack       = wr_ack_q;
   assign bus.wr_err       = wr_err_q;
   assign bus.rd_ack       = rd_ack_q;
   assign bus.rd_err       = rd_err_q;

endmodule

// File: tb/tb_dmac_fifo_param.sv
// tb/tb_dmac_fifo_param.sv - directed and random checks of dmac_fifo_param against a queue model
module tb_dmac_fifo_param;

   localparam int S_IDLE = 0, S_WRITE = 1, S_READ = 2, S_WR_ERROR = 3, S_RD_ERROR = 4, S_WR_RD = 5;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        wr_en = 1'b0, rd_en = 1'b0;
   logic [31:0] din = '0;

   int passed = 0, total = 0, failed = 0;

   logic [31:0] q[$];
   logic [31:0] e_dout;
   int          e_state;
   bit          e_wa, e_we, e_ra, e_re;

   dmac_fifo_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus0 ();
   dmac_fifo_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus1 ();

   assign bus0.wr_en = wr_en;
   assign bus0.rd_en = rd_en;
   assign bus0.din   = din;
   assign bus1.wr_en = wr_en;
   assign bus1.rd_en = rd_en;
   assign bus1.din   = din;

   dmac_fifo_param dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

   dmac_fifo_param #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int c;
      c = q.size();
      chk({tag, " state"},   64'(bus0.state),      64'(e_state));
      chk({tag, " dout"},    64'(bus0.dout),       64'(e_dout));
      chk({tag, " count"},   64'(bus0.data_count), 64'(c));
      chk({tag, " full"},    64'(bus0.full),       64'(c == DEPTH));
      chk({tag, " empty"},   64'(bus0.empty),      64'(c == 0));
      chk({tag, " af"},      64'(bus0.almost_full),  64'(c >= DEPTH - 1));
      chk({tag, " ae"},      64'(bus0.almost_empty), 64'(c <= 1));
      chk({tag, " wr_ack"},  64'(bus0.wr_ack),     64'(e_wa));
      chk({tag, " wr_err"},  64'(bus0.wr_err),     64'(e_we));
      chk({tag, " rd_ack"},  64'(bus0.rd_ack),     64'(e_ra));
      chk({tag, " rd_err"},  64'(bus0.rd_err),     64'(e_re));
      chk({tag, " t.state"}, 64'(bus1.state),      64'(e_state));
      chk({tag, " t.dout"},  64'(bus1.dout),       64'(e_dout));
      chk({tag, " t.count"}, 64'(bus1.data_count), 64'(c));
      chk({tag, " t.af6"},   64'(bus1.almost_full),  64'(c >= 6));
      chk({tag, " t.ae2"},   64'(bus1.almost_empty), 64'(c <= 2));
   endtask

   task automatic model_reset();
      q.delete();
      e_dout  = '0;
      e_state = S_IDLE;
      {e_wa, e_we, e_ra, e_re} = 4'b0000;
   endtask

   // Drive one request, let one rising edge take it, then compare against the queue model.
   task automatic step(input bit w, input bit r, input logic [31:0] d, input string tag);
      bit acc_w, acc_r;
      wr_en = w;
      rd_en = r;
      din   = d;
      @(posedge clk);
      #1;
      acc_r = r && (q.size() != 0);
      acc_w = w && ((q.size() != DEPTH) || acc_r);
      if (acc_r) e_dout = q.pop_front();
      if (acc_w) q.push_back(d);
      e_wa = acc_w;
      e_we = w && !acc_w;
      e_ra = acc_r;
      e_re = r && !acc_r;
      if (acc_w && acc_r)  e_state = S_WR_RD;
      else if (acc_w)      e_state = S_WRITE;
      else if (acc_r)      e_state = S_READ;
      else if (w)          e_state = S_WR_ERROR;
      else if (r)          e_state = S_RD_ERROR;
      else                 e_state = S_IDLE;
      check_all(tag);
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      model_reset();
      #2 reset_n = 1'b0;
      #1 check_all("reset");
      @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      step(0, 0, 32'h0, "idle");

      for (int i = 1; i <= 8; i++) step(1, 0, 32'(i * 'h11), $sformatf("fill%0d", i));
      step(1, 0, 32'h99, "overfill");
      for (int i = 1; i <= 8; i++) step(0, 1, 32'h0, $sformatf("drain%0d", i));
      step(0, 1, 32'h0, "underrun");

      for (int i = 0; i < 6; i++) step(1, 0, 32'hA0 + 32'(i), "wrap_w6");
      for (int i = 0; i < 6; i++) step(0, 1, 32'h0, "wrap_r6");
      for (int i = 0; i < 5; i++) step(1, 0, 32'hB0 + 32'(i), "wrap_w5");
      for (int i = 0; i < 5; i++) step(0, 1, 32'h0, "wrap_r5");

      for (int i = 0; i < 3; i++) step(1, 0, 32'hC0 + 32'(i), "pre3");
      step(1, 1, 32'hC3, "both_at3");
      for (int i = 0; i < 3; i++) step(0, 1, 32'h0, "to_empty");
      step(1, 1, 32'hD0, "both_empty");
      for (int i = 0; i < 7; i++) step(1, 0, 32'hE0 + 32'(i), "to_full");
      step(1, 1, 32'hEF, "both_full");

      for (int i = 0; i < 3; i++) step(0, 1, 32'h0, "to5");
      wr_en = 1'b1;
      din   = 32'h5A;
      #3 reset_n = 1'b0;
      model_reset();
      #1 check_all("async_reset");
      @(posedge clk);
      #1 check_all("held_reset");
      @(negedge clk) reset_n = 1'b1;
      step(1, 0, 32'hAB, "first_after_reset");

      for (int i = 0; i < 300; i++) begin
         int  wp;
         bit  w, r;
         wp = ((i / 40) % 2 == 0) ? 70 : 30;
         w  = $urandom_range(0, 99) < wp;
         r  = $urandom_range(0, 99) < (100 - wp);
         step(w, r, $urandom, $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmac_fifo_param.md
DMAC_FIFO_PARAM -- requirements
Module: dmac_fifo_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 3, SHALL set the pointer width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, SHALL set the almost_full threshold; AE_LEVEL, default 1, SHALL set the almost_empty threshold.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 wr_en  in  1  write request; din  in  DATA_WIDTH  write data.
REQ-007 rd_en  in  1  read request; dout  out  DATA_WIDTH  read data, registered.
REQ-008 full, empty, almost_full, almost_empty  out  1 each  occupancy flags.
REQ-009 wr_ack, wr_err, rd_ack, rd_err  out  1 each  one-cycle result pulses for the previous cycle's request.
REQ-010 data_count  out  ADDR_WIDTH+1  current entry count, 0..DEPTH.
REQ-011 state  out  3  current controller state, encoding from the shared package.

Function
REQ-012 Controller SHALL be a registered FSM with states IDLE=0, WRITE=1, READ=2, WR_ERROR=3, RD_ERROR=4, WR_RD=5; state reflects the operation accepted on the previous edge.
REQ-013 Next state: wr_en&!rd_en -> WRITE if !full else WR_ERROR; rd_en&!wr_en -> READ if !empty else RD_ERROR; neither -> IDLE.
REQ-014 wr_en&rd_en with !empty&!full -> WR_RD: write at tail, read at head, data_count unchanged.
REQ-015 wr_en&rd_en while empty -> WRITE accepted, read rejected: state WRITE, rd_err pulses, wr_ack pulses.
REQ-016 wr_en&rd_en while full -> WR_RD accepted; dout SHALL return the old entry at head (read-before-write), count stays DEPTH.
REQ-017 Accepted write: mem[tail]<=din, tail<=tail+1 modulo DEPTH, data_count+1.
REQ-018 Accepted read: dout<=mem[head] on the same edge (latency 1 cycle from rd_en to valid dout), head<=head+1 modulo DEPTH, data_count-1.
REQ-019 Rejected write/read SHALL leave memory, head, tail, data_count and dout unchanged.
REQ-020 wr_ack/rd_ack/wr_err/rd_err SHALL be registered, high exactly one cycle after the request edge, low otherwise.
REQ-021 full = (data_count==DEPTH); empty = (data_count==0); almost_full = (data_count>=AF_LEVEL); almost_empty = (data_count<=AE_LEVEL); all decoded from registered count, no input-to-flag combinational path.
REQ-022 Pointers SHALL be ADDR_WIDTH bits and wrap naturally; data_count arithmetic SHALL be ADDR_WIDTH+1 bits and never exceed DEPTH or go below 0.
REQ-023 dout SHALL hold its last value when no read is accepted.

Reset
REQ-024 reset_n low SHALL immediately force state=IDLE, head=0, tail=0, data_count=0, dout=0, all ack/err pulses 0; hence empty=1, almost_empty=1, full=0, almost_full=0.
REQ-025 Memory array SHALL not be reset; contents are don't-care after reset.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight request; first request after reset_n release is honoured on the first rising edge with reset_n high.

Structure
REQ-027 State encodings and default DATA_WIDTH/ADDR_WIDTH SHALL live in shared package dmac_fifo_pkg.
REQ-028 Next-pointer/next-count/enable logic SHALL be one combinational sub-module dmac_fifo_next_calc (inputs state request, head, tail, count, full, empty; outputs we, re, next_head, next_tail, next_count, next_state).
REQ-029 Top SHALL contain the registers, memory array and flag decode only.

Verification
REQ-030 Reset then 8 writes 0x11..0x88 (default params) -> wr_ack x8, full=1 after 8th, data_count=8; 9th write -> wr_err, state=WR_ERROR, count stays 8.
REQ-031 From full, 8 reads -> dout 0x11..0x88 in order, each valid one cycle after rd_en; 9th read -> rd_err, state=RD_ERROR, dout stays 0x88.
REQ-032 Wrap: write 6, read 6, write 5 -> tail wraps to 3, reads return data in order, count tracks 5->0.
REQ-033 Simultaneous wr_en&rd_en at count 3 -> state WR_RD, count 3; at empty -> wr_ack and rd_err, count 1; at full -> dout=old head, count 8.
REQ-034 Thresholds AF_LEVEL=6, AE_LEVEL=2: almost_full rises at count 6, almost_empty falls at count 3.
REQ-035 Assert reset_n low mid-burst at count 5 -> outputs per REQ-024 asynchronously, before next clock edge.
